des_top: RTL and testbench
==========================

# des_top

Iterative DES (FIPS 46-3) encryption engine. Accepts a 64-bit plaintext block and a 64-bit key, runs the 16 Feistel rounds one per clock, and presents the 64-bit ciphertext with a one-cycle completion pulse. It is the top of the DES datapath and sits directly behind the block-cipher request interface. It is encrypt-only; there is no decrypt mode.

## Interface

Parameters: none.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled on the rising edge of clk.
- plaintext  input  64  input block; DES bit 1 = bit [63].
- key  input  64  DES key including parity bits; DES bit 1 = bit [63].
- ciphertext  output  64  registered result; holds its value until the next completion.
- busy  output  1  high while rounds are in progress.
- done  output  1  one-cycle pulse; ciphertext is valid in that cycle.

## Operation

- Standard DES in the FIPS ordering: IP, then 16 rounds of L/R Feistel with f(R,K) = P(S(E(R) xor K)), then a final swap (R16‖L16), then FP = IP⁻¹.
- Key schedule:
  - PC-1 maps 64 bits to C0/D0 of 28 bits each.
  - Rounds 1, 2, 9 and 16 use a left-rotate of 1; all other rounds use 2.
  - PC-2 maps C‖D to the 48-bit round key.
- Key parity bits (DES bits 8, 16, …, 64, i.e. key[56], key[48], …, key[0]) are ignored. No parity check is performed.
- S-box addressing: row = bits 1 and 6 of each 6-bit group, column = bits 2–5. Group 1 is the MSB group.
- Accept: when busy=0 and start=1 at an edge, latch IP(plaintext) into L/R and PC-1(key) into C/D. Set busy=1 and round counter=0.
- Round: on each edge while busy=1:
  - rotate C/D by the shift for this round;
  - compute the round with PC-2 of the rotated C/D;
  - update L/R;
  - increment the counter.
- Completion: on the edge that executes round 16:
  - write FP(R16‖L16) to ciphertext;
  - set done=1 and busy=0.
- done=1 lasts exactly one cycle.
- A start seen while busy=1 is ignored, with no queuing. plaintext and key may change freely after the accept edge.
- A start asserted in the cycle where done=1 is accepted, because busy=0 in that cycle.

## Timing

- Reset values: ciphertext=64'h0, busy=0, done=0, round counter=0, L/R/C/D=0.
- Reset asserted mid-operation aborts the computation immediately. The next operation needs a fresh start.
- Latency:
  - start sampled at edge N;
  - rounds execute at edges N+1 … N+16;
  - done=1 and the new ciphertext are visible after edge N+16;
  - busy is high after edges N … N+15.
- Throughput: one block per 17 cycles when start is held high continuously. Back-to-back accepts happen on the done cycle.
- No combinational path from the inputs to any output.

## Structure

- Package des_pkg holds:
  - permutation tables as constants or functions: IP, FP, E, P, PC-1, PC-2;
  - the 16-entry shift schedule;
  - the eight S-box tables (4×16 of 4 bits each);
  - a helper function for the f-function.
- Sub-module des_round: purely combinational. Inputs L, R (32 bits each) and a 48-bit round key; outputs the next L and R. Instantiated once.
- des_top holds the control counter, the C/D key registers, the L/R registers and the output register.

## Test plan

- Reset, then start with key=64'h133457799BBCDFF1 and plaintext=64'h0123456789ABCDEF -> done after exactly 16 edges; ciphertext=64'h85E813540F0AB405.
- key=64'h0, plaintext=64'h0 -> ciphertext=64'h8CA64DE9C1B123A7.
- key=64'h0E329232EA6D0D73, plaintext=64'h8787878787878787 -> ciphertext=64'h0000000000000000.
- Parity invariance: the first vector with key=64'h123456789ABCDEF0 (only LSB of each byte flipped relative to 64'h133457799BBCDFF1) -> identical ciphertext 64'h85E813540F0AB405.
- Pulse start again at edges N+5 and N+10 while busy -> ignored; a single done; the result is for the first vector.
- Back-to-back and reset:
  - start held high across two operations -> the second is accepted on the done cycle and completes 17 cycles after the first done;
  - rst_n pulsed low at round 8 -> ciphertext=0, busy=0, and no done.

Source files
------------

// File: rtl/des_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | des_pkg : DES tables, shift schedule and f-function helper           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package des_pkg;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} des_state_e;

  // Tables hold 1-based FIPS bit numbers; bit 1 is the MSB of the vector.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                              62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                              57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                              61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                              38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                              36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                              34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                             12,13,14,15,16,17, 16,17,18,19,20,21,
                             20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                               10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                               63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                               14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                               16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                               44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Indexed [box][{row,col}]
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - IP_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - FP_T[i])];
    return o;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] d);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = d[6'(64 - PC1_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] d);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = d[6'(56 - PC2_T[i])];
    return o;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  six;
    x = '0;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[i])];
    x = x ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      six = x[6'(47 - 6 * i) -: 6];
      s[5'(31 - 4 * i) -: 4] = 4'(SBOX[3'(i)][{six[5], six[0], six[4:1]}]);
    end
    o = '0;
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = s[5'(32 - P_T[i])];
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_round.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | des_round : one combinational Feistel round                          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o
);

  assign l_o = r_i;
  assign r_o = l_i ^ des_f(r_i, k_i);

endmodule
`default_nettype wire

// File: rtl/des_top.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | des_top : iterative DES encryptor, one round per clock               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module des_top
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] plaintext,
  input  logic [63:0] key,
  output logic [63:0] ciphertext,
  output logic        busy,
  output logic        done
);

  des_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] ct_q, ct_d;
  logic        done_q, done_d;

  logic        w_one;
  logic [27:0] w_c_rot, w_d_rot;
  logic [47:0] w_rk;
  logic [31:0] w_l_nxt, w_r_nxt;

  assign w_one   = (SHIFTS[cnt_q] == 1);
  assign w_c_rot = w_one ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
  assign w_d_rot = w_one ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
  assign w_rk    = pc2_perm({w_c_rot, w_d_rot});

  des_round u_round (
    .l_i (l_q),
    .r_i (r_q),
    .k_i (w_rk),
    .l_o (w_l_nxt),
    .r_o (w_r_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          {l_d, r_d} = ip_perm(plaintext);
          {c_d, d_d} = pc1_perm(key);
          cnt_d      = 4'd0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        c_d   = w_c_rot;
        d_d   = w_d_rot;
        l_d   = w_l_nxt;
        r_d   = w_r_nxt;
        cnt_d = cnt_q + 4'd1;
        // Round 16 output is swapped before the final permutation.
        if (cnt_q == 4'd15) begin
          ct_d    = fp_perm({w_r_nxt, w_l_nxt});
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  assign ciphertext = ct_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_des_top.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_des_top : directed scoreboard bench for des_top                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_des_top;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] plaintext;
  logic [63:0] key;
  logic [63:0] ciphertext;
  logic        busy;
  logic        done;

  int          checks;
  int          errors;
  logic [63:0] sb_q[$];

  des_top dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sb_pop();
    if (sb_q.size() == 0) return 64'hDEAD_DEAD_DEAD_DEAD;
    return sb_q.pop_front();
  endfunction

  // Counts rising edges until done is seen at the following falling edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic run_vec(input string tag, input logic [63:0] pt, input logic [63:0] k,
                         input logic [63:0] exp);
    int lat;
    @(negedge clk);
    plaintext = pt;
    key       = k;
    start     = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    plaintext = ~pt;
    key       = ~k;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'd16);
    check({tag, "_ct"}, ciphertext, sb_pop());
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, ciphertext, exp);
  endtask

  initial begin
    int lat;
    int n_done;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    repeat (3) @(negedge clk);
    check("rst_ct", ciphertext, 64'h0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    run_vec("v1", 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    run_vec("v0", 64'h0, 64'h0, 64'h8CA64DE9C1B123A7);
    run_vec("vz", 64'h8787878787878787, 64'h0E329232EA6D0D73, 64'h0000000000000000);
    run_vec("par", 64'h0123456789ABCDEF, 64'h123456789ABCDEF0, 64'h85E813540F0AB405);

    // Starts during busy must be ignored.
    @(negedge clk);
    plaintext = 64'h0123456789ABCDEF;
    key       = 64'h133457799BBCDFF1;
    start     = 1'b1;
    sb_q.push_back(64'h85E813540F0AB405);
    @(posedge clk);
    n_done = 0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      start     = (e == 5 || e == 10);
      plaintext = 64'h0;
      key       = 64'h0;
      if (done) n_done++;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    check("ign_done_at16", 64'(done), 64'd1);
    check("ign_ct", ciphertext, sb_pop());
    if (done) n_done++;
    repeat (20) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("ign_single_done", 64'(n_done), 64'd1);
    check("ign_idle", 64'(busy), 64'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    plaintext = 64'h0123456789ABCDEF;
    key       = 64'h133457799BBCDFF1;
    start     = 1'b1;
    sb_q.push_back(64'h85E813540F0AB405);
    @(posedge clk);
    @(negedge clk);
    plaintext = 64'h0;
    key       = 64'h0;
    sb_q.push_back(64'h8CA64DE9C1B123A7);
    wait_done(lat);
    check("b2b_lat1", 64'(lat), 64'd16);
    check("b2b_ct1", ciphertext, sb_pop());
    wait_done(lat);
    start = 1'b0;
    check("b2b_lat2", 64'(lat), 64'd17);
    check("b2b_ct2", ciphertext, sb_pop());
    @(negedge clk);
    check("b2b_idle", 64'(busy), 64'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    plaintext = 64'h0123456789ABCDEF;
    key       = 64'h133457799BBCDFF1;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ct", ciphertext, 64'h0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid_rst_no_done", 64'(n_done), 64'd0);
    check("mid_rst_ct_after", ciphertext, 64'h0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
